// File: rtl/tick_meter_pkg.sv
// Shared types for the tick period meter.
package tick_meter_pkg;

   // Measurement FSM: IDLE (disabled), ARM (waiting for first edge),
   // MEASURE (counting between rising edges).
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } meter_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizer plus one delay flop, giving level and single-cycle edge strobes
// for a slow asynchronous input (ticks, divided clocks, buttons).
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic s_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_d_q;

   // Shift the input through the synchronizer; s_d_q lags the synced level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         s_d_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         s_d_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign s_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = s_o & ~s_d_q;
   assign fall_o = ~s_o & s_d_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures period and high time of a slow asynchronous signal in clk cycles.
// Each rising edge closes one period and opens the next; a period that runs
// to TIMEOUT cycles aborts and re-arms.
module tick_period_meter
   import tick_meter_pkg::*;
#(
   parameter int unsigned     WIDTH       = 32,
   parameter longint unsigned TIMEOUT     = 50_000_000,
   parameter int              SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             sig_in,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic             period_valid,
   output logic             timeout
);

   // Last count value before the measurement is abandoned.
   localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(TIMEOUT - 1);

   logic rise, fall;

   meter_state_t     state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [WIDTH-1:0] high_q, high_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .d_i    (sig_in),
      .s_o    (),
      .rise_o (rise),
      .fall_o (fall)
   );

   // Next-state logic; enable low overrides everything, and a rise beats
   // the timeout when both land on the same cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_cnt_d  = hi_cnt_q;
      period_d  = period_q;
      high_d    = high_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;
      if (!enable) begin
         state_d   = IDLE;
         cnt_d     = '0;
         hi_cnt_d  = '0;
         timeout_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_d    = '0;
               hi_cnt_d = '0;
               state_d  = ARM;
            end
            ARM: begin
               // First edge only opens a period; nothing to report yet.
               if (rise) begin
                  cnt_d    = '0;
                  hi_cnt_d = '0;
                  state_d  = MEASURE;
               end
            end
            MEASURE: begin
               cnt_d = cnt_q + WIDTH'(1);
               if (fall) hi_cnt_d = cnt_q + WIDTH'(1);
               if (rise) begin
                  period_d  = cnt_q + WIDTH'(1);
                  high_d    = hi_cnt_q;
                  valid_d   = 1'b1;
                  timeout_d = 1'b0;
                  cnt_d     = '0;
                  hi_cnt_d  = '0;
               end else if (cnt_q == CNT_MAX) begin
                  timeout_d = 1'b1;
                  cnt_d     = '0;
                  hi_cnt_d  = '0;
                  state_d   = ARM;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and output registers, all cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hi_cnt_q  <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_cnt_q  <= hi_cnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   assign period       = period_q;
   assign high_time    = high_q;
   assign period_valid = valid_q;
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_tick_period_meter.sv
`timescale 1ns/1ps
// Self-checking bench for tick_period_meter with TIMEOUT = 16.
module tb_tick_period_meter;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic          sig_in = 1'b0;
   logic [W-1:0]  period, high_time;
   logic          period_valid, timeout;

   tick_period_meter #(.WIDTH(W), .TIMEOUT(16), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .sig_in       (sig_in),
      .period       (period),
      .high_time    (high_time),
      .period_valid (period_valid),
      .timeout      (timeout)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // One sig_in period: rise, hi cycles high, lo cycles low. vld/p/h give the
   // report expected 3 cycles after this rise (closing the previous period);
   // to is the timeout flag expected at that same sample point.
   typedef struct {
      int          hi;
      int          lo;
      bit          vld;
      logic [31:0] p;
      logic [31:0] h;
      logic        to;
   } row_t;

   typedef struct {
      int          due;
      logic [31:0] p;
      logic [31:0] h;
   } exp_t;

   exp_t q[$];
   row_t tbl[11];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   last_rise = 0;

   function automatic row_t mk(int hi, int lo, bit v, int p, int h, bit to);
      row_t r;
      r.hi = hi; r.lo = lo; r.vld = v; r.p = 32'(p); r.h = 32'(h); r.to = to;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: a report must appear exactly on its due cycle, and no
   // valid pulse may appear on any other cycle.
   always @(negedge clk) begin
      if (q.size() > 0 && q[0].due == cyc) begin
         chk("valid", {31'd0, period_valid}, 32'd1);
         chk("period", period, q[0].p);
         chk("high_time", high_time, q[0].h);
         void'(q.pop_front());
      end else if (period_valid) begin
         chk("spurious_valid", {31'd0, period_valid}, 32'd0);
      end
   end

   // Must be entered at a negedge; returns at the negedge ending the period.
   task automatic do_row(input row_t r);
      sig_in = 1'b1;
      last_rise = cyc;
      if (r.vld) q.push_back('{due: cyc + 3, p: r.p, h: r.h});
      for (int k = 0; k < r.hi + r.lo; k++) begin
         if (k == r.hi) sig_in = 1'b0;
         if (k == 3) chk("timeout_flag", {31'd0, timeout}, {31'd0, r.to});
         @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk(4, 6, 0,  0, 0, 0);  // first edge: no report
      tbl[1]  = mk(4, 6, 1, 10, 4, 0);
      tbl[2]  = mk(4, 6, 1, 10, 4, 0);
      tbl[3]  = mk(2, 3, 1, 10, 4, 0);
      tbl[4]  = mk(7, 9, 1,  5, 2, 0);
      tbl[5]  = mk(8, 8, 1, 16, 7, 0);  // period == TIMEOUT
      tbl[6]  = mk(8, 9, 1, 16, 8, 0);  // this period is 17: aborts
      tbl[7]  = mk(3, 5, 0,  0, 0, 1);  // rise after abort only re-opens
      tbl[8]  = mk(4, 6, 1,  8, 3, 0);
      tbl[9]  = mk(5, 5, 1, 10, 4, 0);
      tbl[10] = mk(2, 2, 1, 10, 5, 0);

      // Reset held, then idle with sig_in toggling and enable low.
      repeat (3) @(negedge clk);
      chk("rst_period", period, 32'd0);
      chk("rst_high", high_time, 32'd0);
      chk("rst_valid", {31'd0, period_valid}, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 24; i++) begin
         if (i % 3 == 0) sig_in = ~sig_in;
         @(negedge clk);
      end
      sig_in = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_period", period, 32'd0);
      chk("idle_high", high_time, 32'd0);
      chk("idle_timeout", {31'd0, timeout}, 32'd0);

      // Table-driven measurements.
      enable = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 11; i++) do_row(tbl[i]);

      // Hold low after the last rise: timeout rises exactly 19 cycles later.
      while (cyc < last_rise + 18) @(negedge clk);
      chk("to_before", {31'd0, timeout}, 32'd0);
      @(negedge clk);
      chk("to_after", {31'd0, timeout}, 32'd1);
      repeat (3) @(negedge clk);

      // Enable drop coinciding with a rise.
      do_row(mk(4, 6, 0, 0, 0, 1));
      sig_in = 1'b1;
      repeat (2) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk("drop_period", period, 32'd10);
      chk("drop_high", high_time, 32'd5);
      chk("drop_timeout", {31'd0, timeout}, 32'd0);
      @(negedge clk);
      enable = 1'b1;
      sig_in = 1'b0;
      repeat (6) @(negedge clk);
      do_row(mk(4, 6, 0,  0, 0, 0));
      do_row(mk(3, 5, 1, 10, 4, 0));
      do_row(mk(4, 4, 1,  8, 3, 0));

      // Asynchronous reset while cnt == 5, between clock edges.
      reset = 1'b0;
      #1;
      chk("areset_period", period, 32'd0);
      chk("areset_high", high_time, 32'd0);
      chk("areset_valid", {31'd0, period_valid}, 32'd0);
      chk("areset_timeout", {31'd0, timeout}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      do_row(mk(4, 6, 0,  0, 0, 0));
      do_row(mk(4, 6, 1, 10, 4, 0));
      do_row(mk(4, 4, 1, 10, 4, 0));
      repeat (4) @(negedge clk);
      chk("scoreboard_empty", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/tick_period_meter.md
# tick_period_meter

Measures the period and high time of a slow, asynchronous periodic signal in 50 MHz `clk` cycles. Typical inputs are divided clocks and tick streams produced elsewhere in the design. Each measurement is published as a one-cycle `period_valid` pulse with the period and high time held stable until the next measurement. Sits on the consumer side of the clock-divider chain, for self-check of divider outputs and for frequency readout to display logic.

## Interface
- `WIDTH`, 32: width of the cycle counter and of the `period` and `high_time` outputs.
- `TIMEOUT`, 50_000_000: maximum number of cycles without a rising edge before the measurement aborts. Legal range is 2 to 2^WIDTH-1.
- `SYNC_STAGES`, 2: number of flops in the synchronizer chain on `sig_in`. Minimum value is 2.

Ports:
- `clk`  in  1  system clock, 50 MHz, all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  measurement enable, synchronous.
- `sig_in`  in  1  measured signal, asynchronous to `clk`.
- `period`  out  WIDTH  cycles between the last two detected rising edges.
- `high_time`  out  WIDTH  cycles from a rising edge to the following falling edge, for the period reported in `period`.
- `period_valid`  out  1  one-cycle pulse when `period` and `high_time` update.
- `timeout`  out  1  sticky flag: the last measurement was aborted by `TIMEOUT`.

## Operation
- `sig_in` passes through the `SYNC_STAGES` synchronizer giving `s`, then one more flop giving `s_d`.
  - `rise` = `s & ~s_d`.
  - `fall` = `~s & s_d`.
- States:
  - IDLE: counter held at 0. Moves to ARM when `enable`=1.
  - ARM: waiting for the first edge. On `rise`, clear `cnt` to 0 and move to MEASURE. No `period_valid` is produced for this edge.
  - MEASURE: `cnt` increments every cycle.
    - On `fall`, capture `hi_cnt` ← `cnt`+1.
    - On `rise`:
      - `period` ← `cnt`+1 and `high_time` ← `hi_cnt`.
      - `period_valid` ← 1 and `timeout` ← 0.
      - `cnt` ← 0, `hi_cnt` ← 0, stay in MEASURE.
    - If `cnt` = `TIMEOUT`-1 and there is no `rise`: set `timeout` ← 1 and move to ARM.
- If no `fall` occurred within a period, `high_time` reports 0.
- `enable`=0 in any state:
  - Next state is IDLE and `cnt`/`hi_cnt` are cleared.
  - `timeout` is cleared and `period_valid` is 0.
  - `period` and `high_time` hold their values.
- Simultaneous events:
  - `rise` together with `cnt`=`TIMEOUT`-1: the `rise` wins, giving `period`=`TIMEOUT` and a valid pulse.
  - `rise` together with `enable` falling: `enable` wins, with no valid pulse.
- Arithmetic is unsigned. `cnt` never exceeds `TIMEOUT`-1, so `cnt`+1 never wraps.
- Reset mid-operation: all state is cleared immediately. Reset values:
  - state IDLE, synchronizer and `s_d` all 0;
  - `period`=0, `high_time`=0, `period_valid`=0, `timeout`=0.

## Timing
- Latency: if `sig_in` rises with setup met before clk edge 1, `rise` is high combinationally after edge `SYNC_STAGES`. `period_valid` is then high for exactly the cycle after edge `SYNC_STAGES`+1. For the default, this is the cycle after edge 3.
- `period` and `high_time` change only on the same edge that raises `period_valid`.
- Minimum measurable `sig_in` high or low time is 2 clk cycles. Shorter pulses may be missed; this is not an error condition.
- `timeout` rises on the edge following the cycle where `cnt`=`TIMEOUT`-1.
- Back-to-back measurements need no dead cycle: each `rise` both closes one period and opens the next.

## Structure
- Package `tick_meter_pkg`: `meter_state_t` enum with values IDLE, ARM and MEASURE.
- Sub-module `sync_edge_detect`, parameterised by `SYNC_STAGES`. It contains the synchronizer and the `s_d` flop, and outputs `s`, `rise` and `fall`. It is reusable for button and tick inputs.
- Top level holds the FSM, `cnt`, `hi_cnt` and the output registers.

## Test plan
- Reset and idle: `reset`=0 for 3 cycles, then `enable`=0 with `sig_in` toggling. Required: all outputs stay 0 and no `period_valid` pulse appears.
- Basic measurement: `enable`=1, `sig_in` square wave with period 10 cycles (4 high, 6 low). Required:
  - no pulse on the first rising edge;
  - on every later edge, `period`=10, `high_time`=4 and `period_valid` is high for exactly 1 cycle, 3 cycles after the `sig_in` edge.
- Timeout: with `TIMEOUT`=16, one `sig_in` rise followed by `sig_in` held low. Required:
  - `timeout`=1 on the 16th cycle after `rise`;
  - the next rise gives no `period_valid`;
  - the rise after that reports the correct period and clears `timeout`.
- Boundary: with `TIMEOUT`=16 and a period of exactly 16 cycles, `period`=16 is reported and `timeout` stays 0. A period of 17 cycles triggers `timeout`.
- Enable drop: drop `enable` in the same cycle as `rise`. Required:
  - no `period_valid` and `period` unchanged;
  - after re-enabling, the first edge is not reported and the second edge reports the period.
- Async reset mid-period: assert `reset` while `cnt`=5. Required: outputs are 0 immediately without waiting for a clk edge, and the state returns to IDLE.
